uart_tx_core: RTL
=================

Name: uart_tx_core

Overview:
- Transmit half of the USB-UART serial core; accepts bytes from a byte-level controller over the tdin/wrn/tbre handshake and serialises them onto the UART TX line.
- Double-buffered: one transmit holding register (THR) plus a transmit shift register (TSR). The next byte can be written while the current byte is still shifting out.
- Sits between the loopback/application controller and the board USB-UART bridge pin; targets 1200 baud from the board clock.

Parameters:
- CLKS_PER_BIT, 83333, genclk cycles per serial bit (100 MHz / 1200 baud); legal range 2..131071, 17-bit counter.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- genclk  in  1  system clock; all state on rising edge.
- RST  in  1  reset, synchronous, active-high.
- tdin  in  8  byte to transmit; sampled only on a write.
- wrn  in  1  write strobe, active-high; a one-cycle pulse writes tdin into the THR.
- tbre  out  1  THR status; 0 = THR empty, write accepted; 1 = THR full.
- tsre  out  1  TSR status; 1 = shifter idle, line at mark; 0 = frame in progress.
- tdo  out  1  serial TX line; idles high.
- tovr  out  1  sticky overrun flag; set when a write arrives while tbre=1.

Behaviour:
- Reset (RST=1 at an edge): tdo=1, tbre=0, tsre=1, tovr=0, THR=0, TSR=0, bit/baud counters=0, state=IDLE.
  - Applies mid-frame: the frame is aborted and the line returns to mark on the next cycle. No partial byte resumes.
- Write acceptance:
  - If wrn=1 and tbre=0 at an edge, THR<=tdin and tbre=1 after that edge.
  - If wrn=1 and tbre=1, the write is dropped, THR is unchanged, and tovr=1 (sticky until RST).
  - wrn held high for several cycles counts as one accepted write followed by overrun attempts. Controllers pulse wrn for one cycle.
- State machine, one state per bit slot; each slot lasts exactly CLKS_PER_BIT cycles, counted by the baud counter from 0 to CLKS_PER_BIT-1:
  - IDLE: tdo=1, tsre=1. If tbre=1, transfer on the next edge: TSR<=THR, tbre<=0, tsre<=0, tdo<=0, go to START.
    - Latency: write accepted at edge N, so tdo falls after edge N+1.
  - START: tdo=0 for one bit slot, then DATA.
  - DATA: 8 slots, LSB first. tdo=TSR[0]; shift right at each slot end. The bit counter runs 0..7, then goes to PARITY if PARITY!=0, else to STOP.
  - PARITY: one slot. Odd: tdo = ~^byte. Even: tdo = ^byte. Parity is computed on the byte at transfer time.
  - STOP: tdo=1 for STOP_BITS slots. At the last cycle of the final stop slot:
    - If tbre=1, transfer immediately (same rule as IDLE) and enter START. Back-to-back frames have no idle gap.
    - Else go to IDLE, tsre=1.
- Frame length: (1 + 8 + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles; 8N1 = 10*CLKS_PER_BIT.
- Simultaneous write and THR->TSR transfer at the same edge: tbre is 1 at that edge, so the write is dropped and tovr set. Acceptance depends only on tbre at the sampling edge.
- tdo, tbre, tsre and tovr are registered outputs; there is no combinational path from inputs to outputs.
- tdin changes while tbre=1 or during a frame have no effect.

Test Plan (CLKS_PER_BIT=16 unless stated):
- Reset then idle 100 cycles -> tdo=1, tbre=0, tsre=1, tovr=0 throughout.
- Single write tdin=8'hA5 (PARITY=0), one-cycle wrn -> tbre=1 for 1 cycle; tdo falls 1 cycle after write edge.
  - Line then shows 0,1,0,1,0,0,1,0,1,1, each 16 cycles; tsre returns to 1 after 160 cycles; tovr=0.
- Back-to-back: write 8'h55, then write 8'h0F as soon as tbre=0 -> second start bit follows first stop bit with zero idle cycles; 320 cycles total line activity.
- Overrun: write 8'h11, then write 8'h22 while tbre=1 -> tovr=1 sticky; only 8'h11 transmitted; tbre stays 1 for exactly the cycles before transfer.
- Parity/stop: PARITY=1, STOP_BITS=2, tdin=8'h07 -> parity bit 0 (odd: three ones); stop high 32 cycles; frame length 192 cycles.
  - Repeat with PARITY=2 -> parity bit 1.
- Reset mid-frame: RST asserted during DATA bit 3 of 8'h00 -> tdo=1, tsre=1, tbre=0 one cycle later.
  - A subsequent write of 8'hFF transmits a clean full frame.

Source files
------------

// File: rtl/uart_tx_core_if.sv
// Byte-side handshake between the transmit controller and the UART TX core.
// The serial line and the status flags are carried here as well, so a single bus covers the core.
interface uart_tx_core_if;
    logic [7:0] tdin;
    logic       wrn;
    logic       tbre;
    logic       tsre;
    logic       tdo;
    logic       tovr;

    modport master (
        output tdin,
        output wrn,
        input  tbre,
        input  tsre,
        input  tdo,
        input  tovr
    );

    modport slave (
        input  tdin,
        input  wrn,
        output tbre,
        output tsre,
        output tdo,
        output tovr
    );
endinterface

// File: rtl/uart_tx_core.sv
// Double-buffered UART transmitter: a holding register (THR) feeds a shift register (TSR).
// The frame is start, 8 data bits LSB first, optional parity, then 1 or 2 stop bits.
module uart_tx_core #(
    parameter int CLKS_PER_BIT = 83333,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic          genclk,
    input  logic          RST,
    uart_tx_core_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [16:0] BAUD_LAST = 17'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

    state_t      state_q, state_d;
    logic [16:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  thr_q, thr_d;
    logic [7:0]  tsr_q, tsr_d;
    logic        par_q, par_d;
    logic        tbre_q, tbre_d;
    logic        tsre_q, tsre_d;
    logic        tdo_q, tdo_d;
    logic        tovr_q, tovr_d;
    logic        slot_end;
    logic        load;

    assign slot_end = (baud_q == BAUD_LAST);

    always_ff @(posedge genclk) begin
        if (RST) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            thr_q   <= '0;
            tsr_q   <= '0;
            par_q   <= 1'b0;
            tbre_q  <= 1'b0;
            tsre_q  <= 1'b1;
            tdo_q   <= 1'b1;
            tovr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            thr_q   <= thr_d;
            tsr_q   <= tsr_d;
            par_q   <= par_d;
            tbre_q  <= tbre_d;
            tsre_q  <= tsre_d;
            tdo_q   <= tdo_d;
            tovr_q  <= tovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        thr_d   = thr_q;
        tsr_d   = tsr_q;
        par_d   = par_q;
        tbre_d  = tbre_q;
        tsre_d  = tsre_q;
        tdo_d   = tdo_q;
        tovr_d  = tovr_q;
        load    = 1'b0;

        // Acceptance looks only at the registered tbre, so a write colliding with a transfer is dropped.
        if (bus.wrn) begin
            if (tbre_q) begin
                tovr_d = 1'b1;
            end else begin
                thr_d  = bus.tdin;
                tbre_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                tdo_d  = 1'b1;
                tsre_d = 1'b1;
                if (tbre_q) begin
                    load = 1'b1;
                end
            end
            S_START: begin
                if (slot_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tdo_d   = tsr_q[0];
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 17'd1;
                end
            end
            S_DATA: begin
                if (slot_end) begin
                    baud_d = '0;
                    tsr_d  = {1'b0, tsr_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d = '0;
                        if (PARITY != 0) begin
                            tdo_d   = par_q;
                            state_d = S_PARITY;
                        end else begin
                            tdo_d   = 1'b1;
                            state_d = S_STOP;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tdo_d = tsr_q[1];
                    end
                end else begin
                    baud_d = baud_q + 17'd1;
                end
            end
            S_PARITY: begin
                if (slot_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tdo_d   = 1'b1;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + 17'd1;
                end
            end
            S_STOP: begin
                if (slot_end) begin
                    baud_d = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_d = '0;
                        if (tbre_q) begin
                            load = 1'b1;
                        end else begin
                            tdo_d   = 1'b1;
                            tsre_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 17'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
                bit_d   = '0;
                tdo_d   = 1'b1;
                tsre_d  = 1'b1;
            end
        endcase

        // Parity is frozen here so that later THR writes cannot disturb the frame in flight.
        if (load) begin
            tsr_d   = thr_q;
            par_d   = (PARITY == 1) ? ~^thr_q : ^thr_q;
            tbre_d  = 1'b0;
            tsre_d  = 1'b0;
            tdo_d   = 1'b0;
            baud_d  = '0;
            bit_d   = '0;
            state_d = S_START;
        end
    end

    assign bus.tbre = tbre_q;
    assign bus.tsre = tsre_q;
    assign bus.tdo  = tdo_q;
    assign bus.tovr = tovr_q;

endmodule
